// File: rtl/packet_sram_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | packet_sram_responder_pkg : shared word width, depths, FSM states, entries  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

package packet_sram_responder_pkg;

  localparam int unsigned PKT_W             = `PACKET_SIZE;
  localparam int unsigned DEPTH_DEFAULT     = 256;
  localparam int unsigned BUF_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic             last;
    logic [PKT_W-1:0] data;
  } rsp_entry_t;

  // A word ends the stream when it sits at the top address or is all-zero.
  function automatic logic is_terminator(input logic [PKT_W-1:0] data,
                                         input logic             at_top);
    return at_top | (data == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/packet_sram_responder_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rsp_fifo : response buffer holding packet word plus stream_end flag         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rsp_fifo
  import packet_sram_responder_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT,
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  rsp_entry_t    push_entry_i,
  input  logic          pop_i,
  output rsp_entry_t    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  rsp_entry_t    slot_q [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(BUF_DEPTH));
  assign count_o = count_q;
  assign head_o  = slot_q[rd_ptr_q];

  // A push into a full buffer is legal only when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | packet_sram_responder : host-loaded packet store serving buffered reads     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module packet_sram_responder
  import packet_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [AW-1:0]           load_addr,
  input  logic [`PACKET_SIZE-1:0] load_data,
  input  logic                    load_done,
  input  logic                    bank_busy,
  input  logic                    req_valid,
  input  logic [AW-1:0]           req_addr,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [`PACKET_SIZE-1:0] rsp_data,
  input  logic                    rsp_ready,
  output logic                    stream_end,
  output logic                    store_ready
);

  state_e           state_q;
  state_e           state_d;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] rd_data_q;
  logic             rd_last_q;
  logic             inflight_q;
  logic             mem_we;
  logic             req_fire;
  logic             pop;
  logic             has_credit;
  logic [CW:0]      credit_use;
  rsp_entry_t       push_entry;
  rsp_entry_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  assign req_fire = req_valid & req_ready;
  assign pop      = rsp_valid & rsp_ready;

  // Occupancy is taken after this cycle's pop so a drained head frees a slot
  // immediately, which sustains one response per cycle with BUF_DEPTH=2.
  assign credit_use = (CW+1)'(fifo_count) - (CW+1)'(pop) + (CW+1)'(inflight_q);
  assign has_credit = ~(fifo_full & ~pop) & (credit_use < (CW+1)'(BUF_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (load_done)               state_d = ST_SERVE;
      ST_SERVE: if (pop & stream_end)        state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty & ~inflight_q) state_d = ST_LOAD;
      default:                               state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    store_ready = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      ST_LOAD:  mem_we = load_valid & ~bank_busy;
      ST_SERVE: begin
        store_ready = 1'b1;
        req_ready   = ~bank_busy & has_credit;
      end
      ST_DRAIN: store_ready = 1'b1;
      default:  ;
    endcase
  end

  // Single-port store: writes only happen in LOAD and reads only in SERVE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
    if (req_fire) begin
      rd_data_q <= mem_q[req_addr];
      rd_last_q <= is_terminator(mem_q[req_addr], req_addr == AW'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= req_fire;
    end
  end

  assign push_entry.data = rd_data_q;
  assign push_entry.last = rd_last_q;

  rsp_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_rsp_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (inflight_q),
    .push_entry_i (push_entry),
    .pop_i        (rsp_ready),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign rsp_valid  = ~fifo_empty;
  assign rsp_data   = head.data;
  assign stream_end = head.last & rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_packet_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_packet_sram_responder : directed self-checking bench                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_packet_sram_responder;
  import packet_sram_responder_pkg::*;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned AW        = 4;
  localparam int unsigned W         = `PACKET_SIZE;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic          load_done;
  logic          bank_busy;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          rsp_ready;
  logic          stream_end;
  logic          store_ready;

  int checks = 0;
  int errors = 0;

  packet_sram_responder #(
    .DEPTH     (DEPTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .bank_busy   (bank_busy),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .stream_end  (stream_end),
    .store_ready (store_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_serve();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  function automatic logic [W-1:0] load_value(input int a);
    case (a)
      0:       return W'(32'h11);
      1:       return W'(32'h22);
      2:       return W'(32'h33);
      3:       return '0;
      default: return W'(32'h100 + a);
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b1;
    step(); step();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (stream_end !== 1'b0) begin errors++; $display("FAIL reset_stream_end: got %b expected 0", stream_end); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (store_ready !== 1'b0) begin errors++; $display("FAIL reset_store_ready: got %b expected 0", store_ready); end
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_load();
    for (int a = 0; a < int'(DEPTH); a++) begin
      load_valid = 1'b1; load_addr = AW'(a); load_data = load_value(a);
      req_valid = 1'b1; req_addr = AW'(a);
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_req_ready a=%0d: got %b expected 0", a, req_ready); end
      step();
    end
    load_valid = 1'b0; req_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_no_rsp: got %b expected 0", rsp_valid); end
    checks++; if (store_ready !== 1'b0) begin errors++; $display("FAIL load_store_ready: got %b expected 0", store_ready); end
  endtask

  task automatic finish_stream();
    req_valid = 1'b1; req_addr = AW'(3); rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL finish_req_ready: got %b expected 1", req_ready); end
    step();
    req_valid = 1'b0;
    step();
    #1;
    checks++; if ({rsp_valid, stream_end, rsp_data} !== {1'b1, 1'b1, W'(0)}) begin errors++; $display("FAIL finish_term: got v=%b se=%b d=%h expected v=1 se=1 d=0", rsp_valid, stream_end, rsp_data); end
    step(); step();
    #1;
    checks++; if (store_ready !== 1'b0) begin errors++; $display("FAIL finish_back_to_load: got %b expected 0", store_ready); end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_d [4];
    exp_d[0] = W'(32'h11); exp_d[1] = W'(32'h22); exp_d[2] = W'(32'h33); exp_d[3] = '0;
    go_serve();
    #1;
    checks++; if (store_ready !== 1'b1) begin errors++; $display("FAIL serve_store_ready: got %b expected 1", store_ready); end
    load_valid = 1'b1; load_addr = AW'(1); load_data = W'(32'hDEADBEEF);
    step();
    load_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4); req_addr = AW'(c);
      #1;
      if (c < 4) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_req_ready c=%0d: got %b expected 1", c, req_ready); end
      end
      if (c < 2) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_early c=%0d: got %b expected 0", c, rsp_valid); end
      end else begin
        checks++; if ({rsp_valid, stream_end, rsp_data} !== {1'b1, (c == 5), exp_d[c-2]}) begin errors++; $display("FAIL stream_rsp c=%0d: got v=%b se=%b d=%h expected v=1 se=%b d=%h", c, rsp_valid, stream_end, rsp_data, (c == 5), exp_d[c-2]); end
      end
      step();
    end
    req_valid = 1'b1; req_addr = '0;
    #1;
    checks++; if ({store_ready, req_ready, rsp_valid} !== 3'b100) begin errors++; $display("FAIL drain_state: got sr=%b rr=%b v=%b expected sr=1 rr=0 v=0", store_ready, req_ready, rsp_valid); end
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (store_ready !== 1'b0) begin errors++; $display("FAIL stream_back_to_load: got %b expected 0", store_ready); end
  endtask

  task automatic test_backpressure();
    go_serve();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = AW'(0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %b expected 1", req_ready); end
    step();
    req_addr = AW'(1);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: got %b expected 1", req_ready); end
    step();
    req_addr = AW'(2);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full c=%0d: got %b expected 0", c, req_ready); end
      checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h11)}) begin errors++; $display("FAIL bp_hold c=%0d: got v=%b d=%h expected v=1 d=11", c, rsp_valid, rsp_data); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_data !== W'(32'h11)) begin errors++; $display("FAIL bp_release_d0: got %h expected 11", rsp_data); end
    step();
    req_valid = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h22)}) begin errors++; $display("FAIL bp_d1: got v=%b d=%h expected v=1 d=22", rsp_valid, rsp_data); end
    step();
    #1;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h33)}) begin errors++; $display("FAIL bp_d2: got v=%b d=%h expected v=1 d=33", rsp_valid, rsp_data); end
    step();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", rsp_valid); end
    finish_stream();
  endtask

  task automatic test_bank_busy();
    go_serve();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = AW'(4); bank_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bb_accept: got %b expected 1", req_ready); end
    step();
    req_addr = AW'(5); bank_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bb_blocked c=%0d: got %b expected 0", c, req_ready); end
      if (c == 1) begin
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h104)}) begin errors++; $display("FAIL bb_inflight: got v=%b d=%h expected v=1 d=104", rsp_valid, rsp_data); end
      end
      step();
    end
    bank_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bb_resume: got %b expected 1", req_ready); end
    step();
    req_valid = 1'b0;
    step();
    #1;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h105)}) begin errors++; $display("FAIL bb_next: got v=%b d=%h expected v=1 d=105", rsp_valid, rsp_data); end
    step();
    finish_stream();
  endtask

  task automatic test_read_last();
    go_serve();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = AW'(DEPTH - 1);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL last_accept: got %b expected 1", req_ready); end
    step();
    req_valid = 1'b0;
    step();
    #1;
    checks++; if ({rsp_valid, stream_end, rsp_data} !== {1'b1, 1'b1, W'(32'h10F)}) begin errors++; $display("FAIL last_rsp: got v=%b se=%b d=%h expected v=1 se=1 d=10f", rsp_valid, stream_end, rsp_data); end
    step();
    req_valid = 1'b1; req_addr = '0;
    #1;
    checks++; if ({store_ready, req_ready} !== 2'b10) begin errors++; $display("FAIL last_drain: got sr=%b rr=%b expected sr=1 rr=0", store_ready, req_ready); end
    step();
    req_valid = 1'b0;
    #1;
    checks++; if (store_ready !== 1'b0) begin errors++; $display("FAIL last_to_load: got %b expected 0", store_ready); end
  endtask

  task automatic test_reset_mid();
    go_serve();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = AW'(0);
    step();
    req_addr = AW'(1);
    step();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b expected 1", rsp_valid); end
    reset = 1'b0;
    #1;
    checks++; if ({rsp_valid, store_ready, req_ready, stream_end} !== 4'b0000) begin errors++; $display("FAIL rmid_async: got v=%b sr=%b rr=%b se=%b expected all 0", rsp_valid, store_ready, req_ready, stream_end); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rmid_data: got %h expected 0", rsp_data); end
    req_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    #1;
    checks++; if ({rsp_valid, store_ready} !== 2'b00) begin errors++; $display("FAIL rmid_after: got v=%b sr=%b expected 0 0", rsp_valid, store_ready); end
    go_serve();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = AW'(1);
    step();
    req_addr = AW'(2);
    step();
    req_valid = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h22)}) begin errors++; $display("FAIL rmid_keep1: got v=%b d=%h expected v=1 d=22", rsp_valid, rsp_data); end
    step();
    #1;
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, W'(32'h33)}) begin errors++; $display("FAIL rmid_keep2: got v=%b d=%h expected v=1 d=33", rsp_valid, rsp_data); end
    step();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_flushed: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    bank_busy = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_bank_busy();
    test_read_last();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
